key_cmd_decoder: RTL and testbench

KEY_CMD_DECODER -- requirements
Module: key_cmd_decoder

---
 rtl/key_cmd_decoder.sv | 160 ++++++++++++++++
 tb/tb_key_cmd_decoder.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/key_cmd_decoder.sv
// PS/2 set-2 keyboard command decoder: turns scan-code bytes into per-player direction
// requests, start/escape pulses and a last-code display value.
module key_cmd_decoder (
    input  logic       clk,
    input  logic       reset,
    input  logic       scan_ready,
    input  logic [7:0] scan_code,
    input  logic       game_active,
    input  logic       tick,
    input  logic       load_init,
    output logic       read,
    output logic [1:0] p1_dir,
    output logic [1:0] p2_dir,
    output logic       start_pulse,
    output logic       esc_pulse,
    output logic [7:0] last_code
);

    localparam logic [1:0] DirUp    = 2'b00;
    localparam logic [1:0] DirRight = 2'b01;
    localparam logic [1:0] DirDown  = 2'b10;
    localparam logic [1:0] DirLeft  = 2'b11;

    typedef enum logic [1:0] {StIdle, StDecode, StWaitLow} state_e;

    state_e     state_q, state_d;
    logic [7:0] code_q, code_d;
    logic [7:0] last_q, last_d;
    logic       read_q, read_d;
    logic       ext_q, ext_d;
    logic       brk_q, brk_d;
    logic       start_q, start_d;
    logic       esc_q, esc_d;
    logic [1:0] p1_dir_q, p1_dir_d, p1_pend_q, p1_pend_d;
    logic [1:0] p2_dir_q, p2_dir_d, p2_pend_q, p2_pend_d;
    logic       p1_req, p2_req;
    logic [1:0] req_dir;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= StIdle;
            code_q    <= 8'h00;
            last_q    <= 8'h00;
            read_q    <= 1'b0;
            ext_q     <= 1'b0;
            brk_q     <= 1'b0;
            start_q   <= 1'b0;
            esc_q     <= 1'b0;
            p1_dir_q  <= DirRight;
            p1_pend_q <= DirRight;
            p2_dir_q  <= DirLeft;
            p2_pend_q <= DirLeft;
        end else begin
            state_q   <= state_d;
            code_q    <= code_d;
            last_q    <= last_d;
            read_q    <= read_d;
            ext_q     <= ext_d;
            brk_q     <= brk_d;
            start_q   <= start_d;
            esc_q     <= esc_d;
            p1_dir_q  <= p1_dir_d;
            p1_pend_q <= p1_pend_d;
            p2_dir_q  <= p2_dir_d;
            p2_pend_q <= p2_pend_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        code_d    = code_q;
        last_d    = last_q;
        read_d    = 1'b0;
        ext_d     = ext_q;
        brk_d     = brk_q;
        start_d   = 1'b0;
        esc_d     = 1'b0;
        p1_dir_d  = p1_dir_q;
        p1_pend_d = p1_pend_q;
        p2_dir_d  = p2_dir_q;
        p2_pend_d = p2_pend_q;
        p1_req    = 1'b0;
        p2_req    = 1'b0;
        req_dir   = DirUp;

        case (state_q)
            StIdle: begin
                if (scan_ready) begin
                    code_d  = scan_code;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                read_d  = 1'b1;
                state_d = StWaitLow;
            end
            StWaitLow: begin
                if (!scan_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // read_q marks the cycle after DECODE; effects land on the following edge.
        if (read_q) begin
            if (code_q == 8'hE0) begin
                ext_d = 1'b1;
            end else if (code_q == 8'hF0) begin
                brk_d = 1'b1;
            end else begin
                ext_d = 1'b0;
                brk_d = 1'b0;
                if (!brk_q && !ext_q) begin
                    last_d = code_q;
                    case (code_q)
                        8'h1D: begin p1_req = 1'b1; req_dir = DirUp;    end
                        8'h1B: begin p1_req = 1'b1; req_dir = DirDown;  end
                        8'h1C: begin p1_req = 1'b1; req_dir = DirLeft;  end
                        8'h23: begin p1_req = 1'b1; req_dir = DirRight; end
                        8'h29: start_d = 1'b1;
                        8'h76: esc_d = 1'b1;
                        default: ;
                    endcase
                end else if (!brk_q) begin
                    case (code_q)
                        8'h75: begin p2_req = 1'b1; req_dir = DirUp;    end
                        8'h72: begin p2_req = 1'b1; req_dir = DirDown;  end
                        8'h6B: begin p2_req = 1'b1; req_dir = DirLeft;  end
                        8'h74: begin p2_req = 1'b1; req_dir = DirRight; end
                        default: ;
                    endcase
                    if (p2_req) last_d = code_q;
                end
            end
        end

        // Reversal is judged against the committed direction, not the pending one.
        if (p1_req && game_active && (req_dir != (p1_dir_q ^ 2'b10))) p1_pend_d = req_dir;
        if (p2_req && game_active && (req_dir != (p2_dir_q ^ 2'b10))) p2_pend_d = req_dir;

        if (tick) begin
            p1_dir_d = p1_pend_q;
            p2_dir_d = p2_pend_q;
        end

        if (load_init) begin
            p1_dir_d  = DirRight;
            p1_pend_d = DirRight;
            p2_dir_d  = DirLeft;
            p2_pend_d = DirLeft;
        end
    end

    assign read        = read_q;
    assign p1_dir      = p1_dir_q;
    assign p2_dir      = p2_dir_q;
    assign start_pulse = start_q;
    assign esc_pulse   = esc_q;
    assign last_code   = last_q;

endmodule

// File: tb/tb_key_cmd_decoder.sv
// Scoreboard bench for key_cmd_decoder: driver pushes expected read/pulse events, a monitor
// pops them when the DUT presents them; directions and last_code are checked against a model.
module tb_key_cmd_decoder;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       scan_ready = 1'b0;
    logic [7:0] scan_code = 8'h00;
    logic       game_active = 1'b0;
    logic       tick = 1'b0;
    logic       load_init = 1'b0;
    logic       read;
    logic [1:0] p1_dir, p2_dir;
    logic       start_pulse, esc_pulse;
    logic [7:0] last_code;

    key_cmd_decoder dut (
        .clk        (clk),
        .reset      (reset),
        .scan_ready (scan_ready),
        .scan_code  (scan_code),
        .game_active(game_active),
        .tick       (tick),
        .load_init  (load_init),
        .read       (read),
        .p1_dir     (p1_dir),
        .p2_dir     (p2_dir),
        .start_pulse(start_pulse),
        .esc_pulse  (esc_pulse),
        .last_code  (last_code)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;
    int reads_seen = 0;

    typedef struct {
        logic [1:0] kind;  // 2'b10 start, 2'b01 esc
        int         cyc;
    } pulse_t;

    int     rd_exp[$];
    pulse_t pl_exp[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: decode tables plus player state.
    logic [1:0] p1_map[logic [7:0]];
    logic [1:0] p2_map[logic [7:0]];
    bit         m_ext, m_brk;
    logic [1:0] m_dir1, m_dir2, m_pend1, m_pend2;
    logic [7:0] m_last;

    function automatic void model_reset();
        m_ext = 0; m_brk = 0; m_last = 8'h00;
        m_dir1 = 2'b01; m_pend1 = 2'b01; m_dir2 = 2'b11; m_pend2 = 2'b11;
    endfunction

    function automatic logic [1:0] model_byte(input logic [7:0] b, input bit tk, input bit ld,
                                              input bit ga);
        logic [1:0] kind = 2'b00;
        logic [1:0] old1 = m_pend1;
        logic [1:0] old2 = m_pend2;
        if (b == 8'hE0) m_ext = 1;
        else if (b == 8'hF0) m_brk = 1;
        else begin
            if (!m_brk && !m_ext) begin
                m_last = b;
                if (b == 8'h29) kind = 2'b10;
                if (b == 8'h76) kind = 2'b01;
                if (p1_map.exists(b) && ga && p1_map[b] != (m_dir1 ^ 2'b10)) m_pend1 = p1_map[b];
            end else if (!m_brk && p2_map.exists(b)) begin
                m_last = b;
                if (ga && p2_map[b] != (m_dir2 ^ 2'b10)) m_pend2 = p2_map[b];
            end
            m_ext = 0; m_brk = 0;
        end
        if (tk) begin m_dir1 = old1; m_dir2 = old2; end
        if (ld) begin m_dir1 = 2'b01; m_pend1 = 2'b01; m_dir2 = 2'b11; m_pend2 = 2'b11; end
        return kind;
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, "_p1_dir"}, 32'(p1_dir), 32'(m_dir1));
        check({tag, "_p2_dir"}, 32'(p2_dir), 32'(m_dir2));
        check({tag, "_last_code"}, 32'(last_code), 32'(m_last));
    endtask

    // Byte held h cycles (garbage code after the first); tick/load_init land on decode edge.
    task automatic send_byte(input logic [7:0] b, input int h, input bit tk, input bit ld,
                             input bit ga);
        int         n;
        logic [1:0] kind;
        int         last_j = ((h > 2) ? h : 2) + 2;
        for (int j = 0; j <= last_j; j++) begin
            @(negedge clk);
            if (j == 0) begin
                game_active = ga;
                scan_code   = b;
                n = cyc + 1;
                rd_exp.push_back(n + 1);
                kind = model_byte(b, tk, ld, ga);
                if (kind != 2'b00) pl_exp.push_back('{kind: kind, cyc: n + 2});
            end else if (j < h) begin
                scan_code = 8'($urandom);
            end
            scan_ready = (j < h);
            tick       = tk && (j == 2);
            load_init  = ld && (j == 2);
        end
        check_outputs("byte");
    endtask

    task automatic do_tick();
        @(negedge clk); tick = 1;
        @(negedge clk); tick = 0;
        m_dir1 = m_pend1; m_dir2 = m_pend2;
        check_outputs("tick");
    endtask

    task automatic do_load();
        @(negedge clk); load_init = 1;
        @(negedge clk); load_init = 0;
        m_dir1 = 2'b01; m_pend1 = 2'b01; m_dir2 = 2'b11; m_pend2 = 2'b11;
        check_outputs("load");
    endtask

    // Monitor
    always @(negedge clk) begin
        if (read) begin
            reads_seen++;
            check("read_cycle", 32'(cyc), (rd_exp.size() > 0) ? 32'(rd_exp.pop_front())
                                                                : 32'hFFFF_FFFF);
        end
        if (start_pulse || esc_pulse) begin
            pulse_t e;
            if (pl_exp.size() > 0) e = pl_exp.pop_front();
            else e = '{kind: 2'b11, cyc: -1};
            check("pulse_kind", 32'({start_pulse, esc_pulse}), 32'(e.kind));
            check("pulse_cycle", 32'(cyc), 32'(e.cyc));
        end
    end

    logic [7:0] pool[12] = '{8'hE0, 8'hF0, 8'h1D, 8'h1B, 8'h1C, 8'h23,
                             8'h29, 8'h76, 8'h75, 8'h72, 8'h6B, 8'h74};

    initial begin
        int r0;
        p1_map[8'h1D] = 2'b00; p1_map[8'h1B] = 2'b10; p1_map[8'h1C] = 2'b11; p1_map[8'h23] = 2'b01;
        p2_map[8'h75] = 2'b00; p2_map[8'h72] = 2'b10; p2_map[8'h6B] = 2'b11; p2_map[8'h74] = 2'b01;
        model_reset();

        repeat (3) @(negedge clk);
        reset = 1;
        @(negedge clk);
        check("rst_read", 32'(read), 0);
        check("rst_start", 32'(start_pulse), 0);
        check("rst_esc", 32'(esc_pulse), 0);
        check_outputs("rst");
        do_tick();  // pending must equal committed after reset

        // Scenario 1
        do_load();
        send_byte(8'h1D, 1, 0, 0, 1);
        check("s1_p1_before_tick", 32'(p1_dir), 32'h1);
        do_tick();
        check("s1_p1_after_tick", 32'(p1_dir), 32'h0);
        check("s1_last", 32'(last_code), 32'h1D);

        // Scenario 2
        do_load();
        send_byte(8'h1C, 2, 0, 0, 1);
        do_tick();
        check("s2_p1_reversal", 32'(p1_dir), 32'h1);

        // Scenario 3
        do_load();
        r0 = reads_seen;
        send_byte(8'hE0, 1, 0, 0, 1);
        send_byte(8'h72, 3, 0, 0, 1);
        send_byte(8'hE0, 1, 0, 0, 1);
        send_byte(8'hF0, 2, 0, 0, 1);
        send_byte(8'h72, 1, 0, 0, 1);
        check("s3_read_count", 32'(reads_seen - r0), 5);
        do_tick();
        check("s3_p2_after_tick", 32'(p2_dir), 32'h2);

        // Scenario 4
        send_byte(8'h29, 1, 0, 0, 0);
        send_byte(8'h76, 2, 0, 0, 0);
        do_tick();

        // Scenario 5
        do_load();
        send_byte(8'h1D, 1, 1, 1, 1);
        check("s5_p1", 32'(p1_dir), 32'h1);
        check("s5_p2", 32'(p2_dir), 32'h3);
        do_tick();

        // Scenario 6: pending E0 prefix, then reset in DECODE of 29
        send_byte(8'hE0, 1, 0, 0, 1);
        @(negedge clk); scan_code = 8'h29; scan_ready = 1;
        @(negedge clk); reset = 0; scan_ready = 0;
        @(negedge clk);
        check("s6_read", 32'(read), 0);
        reset = 1;
        model_reset();
        @(negedge clk);
        check("s6_start", 32'(start_pulse), 0);
        check_outputs("s6_rst");
        send_byte(8'h72, 1, 0, 0, 1);  // plain 72 is unlisted once the prefix is gone
        do_tick();

        // Randomized traffic
        for (int i = 0; i < 200; i++) begin
            logic [7:0] b;
            b = ($urandom_range(0, 3) == 0) ? 8'($urandom) : pool[$urandom_range(0, 11)];
            send_byte(b, $urandom_range(1, 3), ($urandom_range(0, 7) == 0),
                      ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0));
            if ($urandom_range(0, 4) == 0) do_tick();
        end

        repeat (4) @(negedge clk);
        check("read_leftover", 32'(rd_exp.size()), 0);
        check("pulse_leftover", 32'(pl_exp.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
